// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use and mul/div stalls,
// taken-branch flushes, mul/div busy tracking and saturating stall/flush counters.
module hazard_stall_controller #(
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_uses_md,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic             md_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t  state_reg, state_next;
    logic [3:0] md_cnt_reg, md_cnt_next;

    logic load_use;
    logic md_hazard;
    logic rs_match;
    logic rt_match;

    // ------------------------------------------------------------------
    // Mul/div FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= MD_IDLE;
            md_cnt_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Mul/div FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        md_cnt_next = md_cnt_reg;
        case (state_reg)
            MD_IDLE: begin
                if (md_start) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = MD_LOAD;
                end
            end
            MD_BUSY: begin
                // A second issue while busy restarts the window rather than queueing.
                if (md_start) begin
                    md_cnt_next = MD_LOAD;
                end else if (md_cnt_reg == 4'd1) begin
                    state_next  = MD_IDLE;
                    md_cnt_next = 4'd0;
                end else begin
                    md_cnt_next = md_cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next  = MD_IDLE;
                md_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mul/div FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        md_busy  = (state_reg == MD_BUSY);
        md_state = state_reg;
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        rs_match  = (ex_rd == id_rs);
        rt_match  = id_uses_rt && (ex_rd == id_rt);
        load_use  = id_valid && ex_memread && (ex_rd != '0) && (rs_match || rt_match);
        md_hazard = id_valid && id_uses_md && md_busy;
    end

    // Taken branch wins: the stalled ID instruction is squashed by the flush anyway.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use || md_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters: 0 = stall cycles, 1 = flush cycles
    // ------------------------------------------------------------------
    logic [1:0]       perf_evt;
    logic [CNT_W-1:0] perf_reg [2];

    always_comb begin
        perf_evt[0] = ~pc_write;
        perf_evt[1] = ifid_flush;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    perf_reg[gi] <= '0;
                end else if (perf_evt[gi] && (perf_reg[gi] != '1)) begin
                    perf_reg[gi] <= perf_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign stall_count = perf_reg[0];
    assign flush_count = perf_reg[1];

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: a behavioural model pushes the
// expected outputs for each cycle, compared at the following falling edge.
module tb_hazard_stall_controller;

    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_uses_rt, id_uses_md, ex_memread, branch_taken, md_start;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_state;
    logic [CNT_W-1:0] stall_count, flush_count;

    hazard_stall_controller #(
        .REG_W(REG_W), .MD_LATENCY(MD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_uses_md(id_uses_md),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .md_start(md_start),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_busy(md_busy), .md_state(md_state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]       ctrl;   // {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_state}
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int               m_busy_left;
    logic [CNT_W-1:0] m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_busy_left = 0;
        m_stall     = '0;
        m_flush     = '0;
    endtask

    // Inputs are already driven (posedge+1); model, push, compare at negedge, advance.
    task automatic step(input string tag);
        exp_t e;
        logic busy, lu, mh, pcw, ifw, fl, bub;
        exp_t got;
        busy = (m_busy_left > 0);
        lu   = id_valid && ex_memread && (ex_rd != 0) &&
               ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
        mh   = id_valid && id_uses_md && busy;
        if (branch_taken) begin
            pcw = 1; ifw = 1; fl = 1; bub = 1;
        end else if (lu || mh) begin
            pcw = 0; ifw = 0; fl = 0; bub = 1;
        end else begin
            pcw = 1; ifw = 1; fl = 0; bub = 0;
        end
        e.ctrl  = {pcw, ifw, fl, bub, busy, busy};
        e.stall = m_stall;
        e.flush = m_flush;
        exp_q.push_back(e);

        @(negedge clk);
        got.ctrl  = {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_state};
        got.stall = stall_count;
        got.flush = flush_count;
        if (exp_q.size() == 0) begin
            check({tag, ":queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ":ctrl"},  32'(got.ctrl),  32'(e.ctrl));
            check({tag, ":stall"}, 32'(got.stall), 32'(e.stall));
            check({tag, ":flush"}, 32'(got.flush), 32'(e.flush));
        end
        $display("cycle %-10s pc_write=%0b ifid_write=%0b flush=%0b bubble=%0b md_busy=%0b stall=%0d flush_cnt=%0d",
                 tag, pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, stall_count, flush_count);

        if (!pcw && m_stall != '1) m_stall = m_stall + 1'b1;
        if (fl && m_flush != '1)   m_flush = m_flush + 1'b1;
        if (md_start)              m_busy_left = MD_LAT;
        else if (m_busy_left > 0)  m_busy_left--;

        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_uses_md = 0;
        ex_memread = 0; ex_rd = 0; branch_taken = 0; md_start = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #2;
        check("rst:ctrl", 32'({pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_state}), 32'b110000);
        check("rst:stall", 32'(stall_count), 32'd0);
        check("rst:flush", 32'(flush_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        step("idle");

        // Load-use on rs, then the same with r0 as destination
        id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs = 5;
        step("lu_rs");
        ex_rd = 0; id_rs = 0;
        step("lu_r0");

        // rt only matters when the instruction reads it
        ex_rd = 7; id_rt = 7; id_rs = 1; id_uses_rt = 0;
        step("rt_unused");
        id_uses_rt = 1;
        step("rt_used");
        id_valid = 0;
        step("rt_novalid");

        // Mul/div issue, then mfhi held in ID across the busy window
        idle_inputs();
        md_start = 1;
        step("md_start");
        md_start = 0; id_valid = 1; id_uses_md = 1;
        for (int i = 1; i <= 5; i++) step($sformatf("mfhi_%0d", i));

        // Branch overrides a simultaneous load-use
        idle_inputs();
        id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs = 5; branch_taken = 1;
        step("br_lu");
        id_valid = 0; ex_memread = 0; branch_taken = 1;
        step("br_novld");

        // Re-issue while busy restarts the window; branch does not cancel it
        idle_inputs();
        md_start = 1;
        step("md_a");
        md_start = 0;
        step("md_b");
        md_start = 1;
        step("md_reissue");
        md_start = 0; branch_taken = 1;
        step("md_br");
        branch_taken = 0; id_valid = 1; id_uses_md = 1;
        for (int i = 0; i < 4; i++) step($sformatf("md_tail%0d", i));

        // Asynchronous reset in the middle of the busy window
        idle_inputs();
        md_start = 1;
        step("md_pre");
        md_start = 0;
        step("md_c1");
        #3;
        reset = 1'b1;
        #1;
        check("arst:busy",  32'(md_busy),     32'd0);
        check("arst:state", 32'(md_state),    32'd0);
        check("arst:stall", 32'(stall_count), 32'd0);
        check("arst:flush", 32'(flush_count), 32'd0);
        check("arst:pcw",   32'(pc_write),    32'd1);
        $display("async reset mid-busy md_busy=%0b stall=%0d", md_busy, stall_count);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        md_start = 1;
        step("md_restart");
        md_start = 0; id_valid = 1; id_uses_md = 1;
        for (int i = 1; i <= 5; i++) step($sformatf("rs_%0d", i));

        // Counter saturation
        idle_inputs();
        id_valid = 1; ex_memread = 1; ex_rd = 9; id_rs = 9;
        for (int i = 0; i < 19; i++) step($sformatf("sat_s%0d", i));
        check("sat:stall15", 32'(stall_count), 32'd15);
        idle_inputs();
        branch_taken = 1;
        for (int i = 0; i < 17; i++) step($sformatf("sat_f%0d", i));
        check("sat:flush15", 32'(flush_count), 32'd15);
        check("sat:stallhold", 32'(stall_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
